// File: rtl/env_sched_pkg.sv
// Shared definitions for the environment step scheduler: FSM state
// encoding, default parameter values and a counter-width helper.
package env_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

    localparam int unsigned DEF_STEPS_PER_FRAME = 1;
    localparam int unsigned DEF_GAP_CYCLES      = 2;
    localparam int unsigned DEF_WATCHDOG_CYCLES = 4096;
    localparam int unsigned DEF_COUNT_BITS      = 16;
    localparam int unsigned DEF_VCOUNT_BITS     = 8;

    // Bits needed to hold values 0..max_val (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/env_step_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear and active-low reset.
// An increment in the same cycle as a clear wins over the clear.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             inc_in,
    input  logic             clr_in,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next value: saturating increment has priority over clear.
    always_comb begin
        count_d = count_q;
        if (inc_in) begin
            if (count_q != '1) begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (clr_in) begin
            count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/env_step_scheduler.sv
// Frame-driven sequencer for the environment update engine. Turns frame
// ticks into engine start pulses, runs STEPS_PER_FRAME passes per frame
// separated by GAP_CYCLES idle cycles, supports pause with single-step,
// counts vertices per pass and dropped (overrun) ticks.
// Optional feature: define STEP_WATCHDOG_EN to abort a pass that does not
// report done within WATCHDOG_CYCLES cycles.
module env_step_scheduler
    import env_sched_pkg::*;
#(
    parameter int unsigned STEPS_PER_FRAME = DEF_STEPS_PER_FRAME,
    parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int unsigned WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES,
    parameter int unsigned COUNT_BITS      = DEF_COUNT_BITS,
    parameter int unsigned VCOUNT_BITS     = DEF_VCOUNT_BITS
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   frame_tick_in,
    input  logic                   pause_in,
    input  logic                   step_req_in,
    input  logic                   clear_err_in,
    input  logic                   env_valid_in,
    input  logic                   env_done_in,
    output logic                   env_start_out,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic [COUNT_BITS-1:0]  frame_count_out,
    output logic [VCOUNT_BITS-1:0] vertex_count_out,
    output logic                   overrun_out,
    output logic [VCOUNT_BITS-1:0] overrun_count_out,
    output logic                   timeout_out
);

    localparam int unsigned SW = cnt_width(STEPS_PER_FRAME);
    localparam int unsigned GW = cnt_width(GAP_CYCLES - 1);

    // Reject parameter values the sequencing cannot honour.
    if (STEPS_PER_FRAME < 1) begin : g_bad_steps
        $error("STEPS_PER_FRAME must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 1");
    end
    if (WATCHDOG_CYCLES < 1) begin : g_bad_wd
        $error("WATCHDOG_CYCLES must be >= 1");
    end

    sched_state_t          state_q, state_d;
    logic [SW-1:0]         steps_q, steps_d;
    logic [GW-1:0]         gap_q,   gap_d;

    logic                  pass_clr;
    logic                  pass_inc;
    logic                  pass_done;
    logic                  frame_fin;
    logic                  abort;
    logic                  overrun_set;
    logic [VCOUNT_BITS-1:0] pass_count;

    logic                  frame_done_q;
    logic [COUNT_BITS-1:0] frame_count_q;
    logic [VCOUNT_BITS-1:0] vertex_count_q;
    logic                  overrun_q;

`ifdef STEP_WATCHDOG_EN
    localparam int unsigned WW = cnt_width(WATCHDOG_CYCLES - 1);
    logic [WW-1:0]         wd_q, wd_d;
    logic                  timeout_q;
`endif

    // State, pass-budget and gap-timer registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            steps_q <= '0;
            gap_q   <= '0;
`ifdef STEP_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            gap_q   <= gap_d;
`ifdef STEP_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        steps_d   = steps_q;
        gap_d     = gap_q;
        pass_clr  = 1'b0;
        pass_inc  = 1'b0;
        pass_done = 1'b0;
        frame_fin = 1'b0;
        abort     = 1'b0;
`ifdef STEP_WATCHDOG_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_tick_in && !pause_in) begin
                    state_d = START;
                    steps_d = SW'(STEPS_PER_FRAME);
                end else if (step_req_in && pause_in) begin
                    state_d = START;
                    steps_d = SW'(1);
                end
            end
            START: begin
                pass_clr = 1'b1;
                gap_d    = '0;
`ifdef STEP_WATCHDOG_EN
                wd_d     = '0;
`endif
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                pass_inc = env_valid_in;
                if (env_done_in) begin
                    pass_done = 1'b1;
                    steps_d   = steps_q - SW'(1);
                    if (steps_q == SW'(1)) begin
                        frame_fin = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = GAP;
                    end
                end
`ifdef STEP_WATCHDOG_EN
                else if (wd_q == WW'(WATCHDOG_CYCLES - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
`endif
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = START;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign overrun_set = frame_tick_in && (state_q != IDLE);

    sat_counter #(.WIDTH(VCOUNT_BITS)) u_pass_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (pass_inc),
        .clr_in    (pass_clr),
        .count_out (pass_count)
    );

    sat_counter #(.WIDTH(VCOUNT_BITS)) u_overrun_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (overrun_set),
        .clr_in    (clear_err_in),
        .count_out (overrun_count_out)
    );

    // Frame completion, vertex latch and sticky error flags.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            frame_done_q   <= 1'b0;
            frame_count_q  <= '0;
            vertex_count_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            frame_done_q <= frame_fin;
            if (frame_fin) begin
                frame_count_q <= frame_count_q + COUNT_BITS'(1);
            end
            if (pass_done) begin
                vertex_count_q <= pass_count;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clear_err_in) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef STEP_WATCHDOG_EN
    // Sticky watchdog flag; a new abort outranks a same-cycle clear.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            timeout_q <= 1'b0;
        end else if (abort) begin
            timeout_q <= 1'b1;
        end else if (clear_err_in) begin
            timeout_q <= 1'b0;
        end
    end
    assign timeout_out = timeout_q;
`else
    assign timeout_out = 1'b0;
`endif

    assign env_start_out    = (state_q == START);
    assign busy_out         = (state_q != IDLE);
    assign frame_done_out   = frame_done_q;
    assign frame_count_out  = frame_count_q;
    assign vertex_count_out = vertex_count_q;
    assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_env_step_scheduler.sv
// Directed bench for env_step_scheduler. Instance a: one pass per frame.
// Instance b: three passes per frame, gap 2, watchdog 16.
module tb_env_step_scheduler;

    logic clk;
    logic rst_n;
    logic tick, pause, step, clr;
    logic valid_a, done_a, valid_b, done_b;

    logic        start_a, busy_a, fd_a, ov_a, to_a;
    logic [15:0] fc_a;
    logic [7:0]  vc_a, ovc_a;
    logic        start_b, busy_b, fd_b, ov_b, to_b;
    logic [15:0] fc_b;
    logic [7:0]  vc_b, ovc_b;

    int n_checks = 0;
    int n_fail   = 0;
    int sc_a     = 0;
    int sc_b     = 0;
    int snap;

    env_step_scheduler u_a (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .frame_tick_in     (tick),
        .pause_in          (pause),
        .step_req_in       (step),
        .clear_err_in      (clr),
        .env_valid_in      (valid_a),
        .env_done_in       (done_a),
        .env_start_out     (start_a),
        .busy_out          (busy_a),
        .frame_done_out    (fd_a),
        .frame_count_out   (fc_a),
        .vertex_count_out  (vc_a),
        .overrun_out       (ov_a),
        .overrun_count_out (ovc_a),
        .timeout_out       (to_a)
    );

    env_step_scheduler #(
        .STEPS_PER_FRAME (3),
        .GAP_CYCLES      (2),
        .WATCHDOG_CYCLES (16)
    ) u_b (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .frame_tick_in     (tick),
        .pause_in          (pause),
        .step_req_in       (step),
        .clear_err_in      (clr),
        .env_valid_in      (valid_b),
        .env_done_in       (done_b),
        .env_start_out     (start_b),
        .busy_out          (busy_b),
        .frame_done_out    (fd_b),
        .frame_count_out   (fc_b),
        .vertex_count_out  (vc_b),
        .overrun_out       (ov_b),
        .overrun_count_out (ovc_b),
        .timeout_out       (to_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Start-pulse counters sampled on the active edge.
    always @(posedge clk) begin
        if (start_a) sc_a <= sc_a + 1;
        if (start_b) sc_b <= sc_b + 1;
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick = 0; pause = 0; step = 0; clr = 0;
        valid_a = 0; done_a = 0; valid_b = 0; done_b = 0;
        step_clk();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        tick = 0; pause = 0; step = 0; clr = 0;
        valid_a = 0; done_a = 0; valid_b = 0; done_b = 0;
        step_clk();
        step_clk();

        // Reset state
        chk("rst_start", start_a, 0);
        chk("rst_busy",  busy_a,  0);
        chk("rst_fd",    fd_a,    0);
        chk("rst_fc",    fc_a,    0);
        chk("rst_vc",    vc_a,    0);
        chk("rst_ov",    ov_a,    0);
        chk("rst_ovc",   ovc_a,   0);
        chk("rst_to",    to_a,    0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        step_clk();

        // One frame, one pass, 5 vertices
        tick = 1;
        step_clk();
        tick = 0;
        chk("t1_start", start_a, 1);
        chk("t1_busy",  busy_a,  1);
        step_clk();
        chk("t1_start_once", start_a, 0);
        valid_a = 1;
        repeat (5) step_clk();
        valid_a = 0;
        done_a  = 1;
        step_clk();
        done_a  = 0;
        chk("t1_fd",   fd_a,   1);
        chk("t1_fc",   fc_a,   1);
        chk("t1_vc",   vc_a,   5);
        chk("t1_idle", busy_a, 0);
        step_clk();
        chk("t1_fd_pulse", fd_a, 0);

        // Reset in the middle of WAIT_DONE, then restart
        tick = 1;
        step_clk();
        tick = 0;
        step_clk();
        valid_a = 1;
        step_clk();
        valid_a = 0;
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        chk("mr_busy",  busy_a,  0);
        chk("mr_start", start_a, 0);
        chk("mr_fc",    fc_a,    0);
        chk("mr_vc",    vc_a,    0);
        tick = 1;
        step_clk();
        tick = 0;
        chk("mr_restart", start_a, 1);
        step_clk();
        valid_a = 1;
        repeat (2) step_clk();
        valid_a = 0;
        done_a  = 1;
        step_clk();
        done_a  = 0;
        chk("mr_fc_after", fc_a, 1);
        chk("mr_vc_after", vc_a, 2);

        // Three passes with a two-cycle gap (instance b)
        reset_dut();
        snap = sc_b;
        tick = 1;
        step_clk();
        tick = 0;
        chk("t2_start0", start_b, 1);
        for (int k = 0; k < 3; k++) begin
            step_clk();
            valid_b = 1;
            repeat (k + 2) step_clk();
            valid_b = 0;
            done_b  = 1;
            step_clk();
            done_b  = 0;
            if (k < 2) begin
                chk("t2_gap1_start", start_b, 0);
                chk("t2_gap1_fd",    fd_b,    0);
                chk("t2_gap1_busy",  busy_b,  1);
                step_clk();
                chk("t2_gap2_start", start_b, 0);
                step_clk();
                chk("t2_restart",    start_b, 1);
            end
        end
        chk("t2_fd",     fd_b,   1);
        chk("t2_fc",     fc_b,   1);
        chk("t2_vc",     vc_b,   4);
        chk("t2_idle",   busy_b, 0);
        step_clk();
        chk("t2_fd_pulse", fd_b, 0);
        chk("t2_starts", sc_b - snap, 3);

        // Overrun, clear, set-wins, tick on return-to-IDLE cycle
        reset_dut();
        snap = sc_a;
        tick = 1;
        step_clk();
        tick = 0;
        step_clk();
        tick = 1;
        step_clk();
        tick = 0;
        chk("ov_flag",    ov_a,    1);
        chk("ov_count",   ovc_a,   1);
        chk("ov_nostart", start_a, 0);
        step = 1;
        step_clk();
        step = 0;
        chk("ov_step_busy_ign", start_a, 0);
        clr = 1;
        step_clk();
        clr = 0;
        chk("clr_flag",  ov_a,  0);
        chk("clr_count", ovc_a, 0);
        tick = 1; clr = 1;
        step_clk();
        clr = 0;
        chk("setwin_flag",  ov_a,  1);
        chk("setwin_count", ovc_a, 1);
        done_a = 1;
        step_clk();
        tick = 0; done_a = 0;
        chk("edge_ovc",  ovc_a,  2);
        chk("edge_fd",   fd_a,   1);
        chk("edge_idle", busy_a, 0);
        step_clk();
        chk("edge_nostart", start_a, 0);
        chk("ov_starts", sc_a - snap, 1);

        // Pause: tick ignored, single step runs one pass
        reset_dut();
        pause = 1;
        tick  = 1;
        step_clk();
        tick  = 0;
        chk("p_tick_ign", busy_a, 0);
        chk("p_no_ov",    ov_a,   0);
        step = 1;
        step_clk();
        step = 0;
        chk("p_step_start", start_a, 1);
        step_clk();
        done_a = 1;
        step_clk();
        done_a = 0;
        chk("p_fd",    fd_a, 1);
        chk("p_fc",    fc_a, 1);
        chk("p_no_ov2", ov_a, 0);
        pause = 0;
        step  = 1;
        step_clk();
        step  = 0;
        chk("p_step_unpaused_ign", busy_a, 0);

        // Vertex counter saturates
        reset_dut();
        tick = 1;
        step_clk();
        tick = 0;
        step_clk();
        valid_a = 1;
        repeat (300) step_clk();
        valid_a = 0;
        done_a  = 1;
        step_clk();
        done_a  = 0;
        chk("sat_vc", vc_a, 255);

        // Engine that never finishes (instance b)
        reset_dut();
        tick = 1;
        step_clk();
        tick = 0;
        step_clk();
`ifdef STEP_WATCHDOG_EN
        repeat (15) step_clk();
        chk("wd_pre_to",   to_b,   0);
        chk("wd_pre_busy", busy_b, 1);
        step_clk();
        chk("wd_to",   to_b,   1);
        chk("wd_busy", busy_b, 0);
        chk("wd_fc",   fc_b,   0);
        chk("wd_fd",   fd_b,   0);
        clr = 1;
        step_clk();
        clr = 0;
        chk("wd_clr", to_b, 0);
`else
        repeat (40) step_clk();
        chk("nowd_busy", busy_b, 1);
        chk("nowd_to",   to_b,   0);
        chk("nowd_fc",   fc_b,   0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
